// File: rtl/frame_read_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_read_gate_pkg
// Description : Shared types for the frame read-release gate: per-channel
//               state encoding used by the channel controller and top level.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_read_gate_pkg;

    localparam int c_ST_W = 2;

    // Per-channel read-release state; encodings are fixed so that the
    // state can be compared against software/debug views directly.
    typedef enum logic [c_ST_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_FILL   = 2'b01,
        ST_STREAM = 2'b10
    } ch_state_e;

endpackage : frame_read_gate_pkg
`default_nettype wire

// File: rtl/frame_read_gate_ch.sv
`default_nettype none
// ============================================================================
// Module      : frame_read_gate_ch
// Description : One buffer channel: IDLE/FILL/STREAM release FSM, occupancy
//               counter (written minus read), per-frame write counter and
//               sticky underrun/overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_read_gate_ch
    import frame_read_gate_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int THRESH     = 512,
    parameter int FRAME_SIZE = 640
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_new_frame_i,
    input  logic             rd_new_frame_i,
    input  logic             wr_valid_i,
    input  logic             rd_req_i,
    output logic             rd_ack_o,
    output logic             read_en_o,
    output logic             wr_frame_done_o,
    output logic             underrun_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] occupancy_o
);

    localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] c_FRAME   = CNT_W'(FRAME_SIZE);
    localparam logic [CNT_W-1:0] c_OCC_MAX = '1;
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic             w_rd_ack;
    logic             w_wr_acc;
    logic             w_cnt_step;
    logic             w_frame_hit;

    // Reads are granted only while streaming and only when data is held.
    assign w_rd_ack = rd_req_i & (state_q == ST_STREAM) & (occ_q != '0);

    // IDLE ignores writes, except the word that arrives with the frame start.
    assign w_wr_acc = wr_valid_i & ((state_q != ST_IDLE) | wr_new_frame_i);

    // Frame complete only on the word that brings the counter to FRAME_SIZE,
    // so a saturated counter does not keep re-triggering the release.
    assign w_frame_hit = w_cnt_step & (wr_cnt_d == c_FRAME);

    // Occupancy update; a write into a full counter is dropped and flagged
    // unless a read in the same cycle makes room for it.
    always_comb begin
        occ_d      = occ_q;
        overflow_d = overflow_q;
        if (w_wr_acc && !w_rd_ack) begin
            if (occ_q == c_OCC_MAX) begin
                overflow_d = 1'b1;
            end else begin
                occ_d = occ_q + c_ONE;
            end
        end else if (!w_wr_acc && w_rd_ack) begin
            occ_d = occ_q - c_ONE;
        end
    end

    // Per-frame write counter; a word coincident with the frame start is word 1.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        w_cnt_step = 1'b0;
        if (wr_new_frame_i) begin
            wr_cnt_d   = w_wr_acc ? c_ONE : '0;
            w_cnt_step = w_wr_acc;
        end else if (w_wr_acc && (wr_cnt_q != c_FRAME)) begin
            wr_cnt_d   = wr_cnt_q + c_ONE;
            w_cnt_step = 1'b1;
        end
        done_d = w_frame_hit;
    end

    // Release FSM; underrun drops back to FILL so the buffer re-primes.
    always_comb begin
        state_d    = state_q;
        underrun_d = rd_new_frame_i ? 1'b0 : underrun_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_new_frame_i) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if ((occ_d >= c_THRESH) || w_frame_hit) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (rd_req_i && (occ_q == '0)) begin
                    underrun_d = 1'b1;
                    state_d    = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset discards any in-flight frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            occ_q      <= '0;
            wr_cnt_q   <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            wr_cnt_q   <= wr_cnt_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign rd_ack_o        = w_rd_ack;
    assign read_en_o       = (state_q == ST_STREAM);
    assign wr_frame_done_o = done_q;
    assign underrun_o      = underrun_q;
    assign overflow_o      = overflow_q;
    assign occupancy_o     = occ_q;

endmodule : frame_read_gate_ch
`default_nettype wire

// File: rtl/frame_read_gate.sv
`default_nettype none
// ============================================================================
// Module      : frame_read_gate
// Description : Multi-channel read-release controller for the frame buffer.
//               Holds each channel's read side off until a prefill level or
//               a full frame has been written; channels are independent.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_read_gate
    import frame_read_gate_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16,
    parameter int THRESH     = 512,
    parameter int FRAME_SIZE = 640
) (
    input  logic                    ctrl_clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       wr_new_frame,
    input  logic [NUM_CH-1:0]       rd_new_frame,
    input  logic [NUM_CH-1:0]       wr_valid,
    input  logic [NUM_CH-1:0]       rd_req,
    output logic [NUM_CH-1:0]       rd_ack,
    output logic [NUM_CH-1:0]       read_en,
    output logic [NUM_CH-1:0]       wr_frame_done,
    output logic [NUM_CH-1:0]       underrun,
    output logic [NUM_CH-1:0]       overflow,
    output logic [NUM_CH*CNT_W-1:0] occupancy
);

    // One independent controller per channel; the top only slices buses.
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            frame_read_gate_ch #(
                .CNT_W      (CNT_W),
                .THRESH     (THRESH),
                .FRAME_SIZE (FRAME_SIZE)
            ) u_ch (
                .clk_i           (ctrl_clk),
                .rst_i           (reset),
                .wr_new_frame_i  (wr_new_frame[g]),
                .rd_new_frame_i  (rd_new_frame[g]),
                .wr_valid_i      (wr_valid[g]),
                .rd_req_i        (rd_req[g]),
                .rd_ack_o        (rd_ack[g]),
                .read_en_o       (read_en[g]),
                .wr_frame_done_o (wr_frame_done[g]),
                .underrun_o      (underrun[g]),
                .overflow_o      (overflow[g]),
                .occupancy_o     (occupancy[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule : frame_read_gate
`default_nettype wire

// File: tb/tb_frame_read_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_read_gate
// Description : Directed bench for frame_read_gate. Three instances cover the
//               default build (A), a short frame (B) and a narrow counter (C).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_read_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Instance A: defaults (THRESH 512, FRAME_SIZE 640)
    logic [1:0]  a_wnf = '0, a_rnf = '0, a_wv = '0, a_rq = '0;
    logic [1:0]  a_ack, a_ren, a_done, a_ur, a_ov;
    logic [31:0] a_occ;
    // Instance B: FRAME_SIZE 100
    logic [1:0]  b_wnf = '0, b_rnf = '0, b_wv = '0, b_rq = '0;
    logic [1:0]  b_ack, b_ren, b_done, b_ur, b_ov;
    logic [31:0] b_occ;
    // Instance C: CNT_W 4, THRESH 8, FRAME_SIZE 15
    logic [1:0]  c_wnf = '0, c_rnf = '0, c_wv = '0, c_rq = '0;
    logic [1:0]  c_ack, c_ren, c_done, c_ur, c_ov;
    logic [7:0]  c_occ;

    frame_read_gate #(.NUM_CH(2), .CNT_W(16), .THRESH(512), .FRAME_SIZE(640)) u_a (
        .ctrl_clk(clk), .reset(rst), .wr_new_frame(a_wnf), .rd_new_frame(a_rnf),
        .wr_valid(a_wv), .rd_req(a_rq), .rd_ack(a_ack), .read_en(a_ren),
        .wr_frame_done(a_done), .underrun(a_ur), .overflow(a_ov), .occupancy(a_occ));

    frame_read_gate #(.NUM_CH(2), .CNT_W(16), .THRESH(512), .FRAME_SIZE(100)) u_b (
        .ctrl_clk(clk), .reset(rst), .wr_new_frame(b_wnf), .rd_new_frame(b_rnf),
        .wr_valid(b_wv), .rd_req(b_rq), .rd_ack(b_ack), .read_en(b_ren),
        .wr_frame_done(b_done), .underrun(b_ur), .overflow(b_ov), .occupancy(b_occ));

    frame_read_gate #(.NUM_CH(2), .CNT_W(4), .THRESH(8), .FRAME_SIZE(15)) u_c (
        .ctrl_clk(clk), .reset(rst), .wr_new_frame(c_wnf), .rd_new_frame(c_rnf),
        .wr_valid(c_wv), .rd_req(c_rq), .rd_ack(c_ack), .read_en(c_ren),
        .wr_frame_done(c_done), .underrun(c_ur), .overflow(c_ov), .occupancy(c_occ));

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        vec++;
        if ({a_ack, a_ren, a_done, a_ur, a_ov} !== 10'b0) begin
            errs++; $display("FAIL reset_a_flags: got %b want 0", {a_ack, a_ren, a_done, a_ur, a_ov});
        end
        vec++;
        if (a_occ !== 32'd0) begin
            errs++; $display("FAIL reset_a_occ: got %0h want 0", a_occ);
        end
        vec++;
        if ({b_ren, b_done, c_ren, c_ov, c_occ} !== 16'b0) begin
            errs++; $display("FAIL reset_bc: got %b want 0", {b_ren, b_done, c_ren, c_ov, c_occ});
        end
        rst = 1'b0;
        tick();
    endtask

    // T1: prefill threshold on A ch0, ch1 untouched
    task automatic test_prefill();
        a_wnf = 2'b01; tick(); a_wnf = 2'b00;
        a_wv = 2'b01;
        for (int i = 0; i < 511; i++) tick();
        vec++;
        if (a_ren !== 2'b00) begin
            errs++; $display("FAIL prefill_511_ren: got %b want 00", a_ren);
        end
        vec++;
        if (a_occ[15:0] !== 16'd511) begin
            errs++; $display("FAIL prefill_511_occ: got %0d want 511", a_occ[15:0]);
        end
        tick();
        a_wv = 2'b00;
        vec++;
        if (a_ren !== 2'b01) begin
            errs++; $display("FAIL prefill_512_ren: got %b want 01", a_ren);
        end
        vec++;
        if (a_occ !== {16'd0, 16'd512}) begin
            errs++; $display("FAIL prefill_512_occ: got %0h want 00000200", a_occ);
        end
        vec++;
        if ({a_ur[1], a_ov[1], a_done[1], a_ren[1]} !== 4'b0) begin
            errs++; $display("FAIL prefill_ch1_idle: got %b want 0000", {a_ur[1], a_ov[1], a_done[1], a_ren[1]});
        end
    endtask

    // T2: full frame releases before threshold on B
    task automatic test_frame_size();
        b_wnf = 2'b01; tick(); b_wnf = 2'b00;
        b_wv = 2'b01;
        for (int i = 0; i < 99; i++) tick();
        vec++;
        if ({b_done, b_ren} !== 4'b0000) begin
            errs++; $display("FAIL frame_99: done/ren got %b want 0000", {b_done, b_ren});
        end
        tick();
        vec++;
        if ({b_done, b_ren} !== 4'b0101) begin
            errs++; $display("FAIL frame_100: done/ren got %b want 0101", {b_done, b_ren});
        end
        vec++;
        if (b_occ[15:0] !== 16'd100) begin
            errs++; $display("FAIL frame_100_occ: got %0d want 100", b_occ[15:0]);
        end
        tick();
        b_wv = 2'b00;
        vec++;
        if (b_done !== 2'b00) begin
            errs++; $display("FAIL frame_101_done: got %b want 00", b_done);
        end
        vec++;
        if (b_occ[15:0] !== 16'd101) begin
            errs++; $display("FAIL frame_101_occ: got %0d want 101", b_occ[15:0]);
        end
        tick();
        vec++;
        if (b_done !== 2'b00) begin
            errs++; $display("FAIL frame_after_done: got %b want 00", b_done);
        end
    endtask

    // T3: drain A to empty, underrun, drop to FILL, clear with rd_new_frame
    task automatic test_underrun();
        a_rq = 2'b01;
        #1;
        vec++;
        if (a_ack !== 2'b01) begin
            errs++; $display("FAIL underrun_first_ack: got %b want 01", a_ack);
        end
        for (int i = 0; i < 511; i++) tick();
        vec++;
        if (a_occ[15:0] !== 16'd1 || a_ren !== 2'b01) begin
            errs++; $display("FAIL underrun_occ1: occ %0d ren %b want 1 01", a_occ[15:0], a_ren);
        end
        vec++;
        if (a_ack !== 2'b01) begin
            errs++; $display("FAIL underrun_ack_last: got %b want 01", a_ack);
        end
        tick();
        vec++;
        if (a_ack !== 2'b00 || a_occ[15:0] !== 16'd0 || a_ur !== 2'b00) begin
            errs++; $display("FAIL underrun_empty: ack %b occ %0d ur %b want 00 0 00", a_ack, a_occ[15:0], a_ur);
        end
        tick();
        a_rq = 2'b00;
        vec++;
        if (a_ur !== 2'b01 || a_ren !== 2'b00) begin
            errs++; $display("FAIL underrun_flag: ur %b ren %b want 01 00", a_ur, a_ren);
        end
        a_rnf = 2'b01; tick(); a_rnf = 2'b00;
        vec++;
        if (a_ur !== 2'b00 || a_ren !== 2'b00 || a_occ[15:0] !== 16'd0) begin
            errs++; $display("FAIL underrun_clear: ur %b ren %b occ %0d want 00 00 0", a_ur, a_ren, a_occ[15:0]);
        end
    endtask

    // T4: simultaneous write and read on B keeps occupancy
    task automatic test_simultaneous();
        b_rq = 2'b01;
        for (int i = 0; i < 96; i++) tick();
        vec++;
        if (b_occ[15:0] !== 16'd5) begin
            errs++; $display("FAIL simul_occ5: got %0d want 5", b_occ[15:0]);
        end
        b_wv = 2'b01;
        #1;
        vec++;
        if (b_ack !== 2'b01) begin
            errs++; $display("FAIL simul_ack: got %b want 01", b_ack);
        end
        tick();
        b_rq = 2'b00; b_wv = 2'b00;
        vec++;
        if (b_occ[15:0] !== 16'd5 || b_ov !== 2'b00) begin
            errs++; $display("FAIL simul_hold: occ %0d ov %b want 5 00", b_occ[15:0], b_ov);
        end
    endtask

    // T5: narrow counter saturates and flags overflow on C
    task automatic test_overflow();
        c_wnf = 2'b01; tick(); c_wnf = 2'b00;
        c_wv = 2'b01;
        for (int i = 0; i < 15; i++) tick();
        vec++;
        if (c_occ !== 8'h0F || c_ov !== 2'b00) begin
            errs++; $display("FAIL ovf_15: occ %0h ov %b want 0f 00", c_occ, c_ov);
        end
        tick();
        c_wv = 2'b00;
        vec++;
        if (c_occ !== 8'h0F || c_ov !== 2'b01) begin
            errs++; $display("FAIL ovf_16: occ %0h ov %b want 0f 01", c_occ, c_ov);
        end
        vec++;
        if (c_ren !== 2'b01) begin
            errs++; $display("FAIL ovf_ren: got %b want 01", c_ren);
        end
    endtask

    // T6: async reset mid-STREAM on B, writes ignored until a new frame
    task automatic test_async_reset();
        b_wv = 2'b01;
        for (int i = 0; i < 295; i++) tick();
        b_wv = 2'b00;
        vec++;
        if (b_occ[15:0] !== 16'd300 || b_ren !== 2'b01) begin
            errs++; $display("FAIL areset_pre: occ %0d ren %b want 300 01", b_occ[15:0], b_ren);
        end
        b_rq = 2'b01;
        #2;
        vec++;
        if (b_ack !== 2'b01) begin
            errs++; $display("FAIL areset_pre_ack: got %b want 01", b_ack);
        end
        rst = 1'b1;
        #1;
        vec++;
        if ({b_ack, b_ren, b_done, b_ur, b_ov} !== 10'b0 || b_occ !== 32'd0) begin
            errs++; $display("FAIL areset_now: flags %b occ %0h want 0 0", {b_ack, b_ren, b_done, b_ur, b_ov}, b_occ);
        end
        vec++;
        if (c_ov !== 2'b00 || c_occ !== 8'h00) begin
            errs++; $display("FAIL areset_c: ov %b occ %0h want 00 00", c_ov, c_occ);
        end
        b_rq = 2'b00;
        #2;
        rst = 1'b0;
        b_wv = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        b_wv = 2'b00;
        vec++;
        if (b_occ[15:0] !== 16'd0 || b_ren !== 2'b00) begin
            errs++; $display("FAIL areset_idle_wr: occ %0d ren %b want 0 00", b_occ[15:0], b_ren);
        end
        b_wnf = 2'b01; tick(); b_wnf = 2'b00;
        b_wv = 2'b01; tick(); b_wv = 2'b00;
        vec++;
        if (b_occ[15:0] !== 16'd1) begin
            errs++; $display("FAIL areset_new_frame: occ %0d want 1", b_occ[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_frame_size();
        test_underrun();
        test_simultaneous();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule : tb_frame_read_gate
`default_nettype wire
